// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 active-low matrix keypad, debounces the result
// and reports single-key presses as a 4-bit code.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   row[3:0]   - keypad rows, active-low, asynchronous; row[0] is the top row
//   col[2:0]   - column drive, active-low, one bit low; col[0] is the left column
//   keyPadBuf  - debounced key code (0-9, A='*', B='#'), 4'hF when idle
//   key_strobe - one-cycle pulse when a press is accepted
//   key_held   - high while an accepted key has not been released
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] keyPadBuf,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int unsigned DW         = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [3:0]    FRAMES     = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_sync_q, row_sync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    slot0_q, slot0_d;
  logic [3:0]    slot1_q, slot1_d;
  state_t        state_q, state_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          strobe_q, strobe_d;
  logic          held_q, held_d;

  logic          last_dwell;
  logic          frame_eval;
  logic [11:0]   low_bits;
  logic [3:0]    nlow;
  logic [3:0]    hit_code;
  logic          is_empty;
  logic          is_single;

  // Bit index is col*4 + row.
  function automatic logic [3:0] code_of(input int unsigned idx);
    int unsigned r;
    int unsigned c;
    r = idx % 4;
    c = idx / 4;
    if (r < 3) begin
      return 4'(r * 3 + c + 1);
    end
    case (c)
      0:       return 4'hA;
      1:       return 4'h0;
      default: return 4'hB;
    endcase
  endfunction

  // Synchronizer, column scan and slot capture.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
    last_dwell = (dwell_q == DWELL_LAST);
    dwell_d    = last_dwell ? '0 : dwell_q + DW'(1);
    col_idx_d  = col_idx_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    if (last_dwell) begin
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      case (col_idx_q)
        2'd0:    slot0_d = row_sync_q;
        2'd1:    slot1_d = row_sync_q;
        default: ;
      endcase
    end
    frame_eval = last_dwell && (col_idx_q == 2'd2);
  end

  // Column 2 is not stored: its sample is used live on the evaluation cycle.
  always_comb begin
    low_bits = ~{row_sync_q, slot1_q, slot0_q};
    nlow     = '0;
    hit_code = 4'hF;
    for (int unsigned i = 0; i < 12; i++) begin
      if (low_bits[i]) begin
        nlow     = nlow + 4'd1;
        hit_code = code_of(i);
      end
    end
    is_empty  = (nlow == 4'd0);
    is_single = (nlow == 4'd1);
  end

  // Debounce FSM: next state and registered outputs.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    cand_d   = cand_q;
    key_d    = key_q;
    held_d   = held_q;
    strobe_d = 1'b0;
    if (frame_eval) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = hit_code;
            fcnt_d = 4'd1;
            if (FRAMES == 4'd1) begin
              key_d    = hit_code;
              strobe_d = 1'b1;
              held_d   = 1'b1;
              state_d  = HELD;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (is_single && (hit_code == cand_q)) begin
            if (fcnt_q + 4'd1 >= FRAMES) begin
              fcnt_d   = FRAMES;
              key_d    = cand_q;
              strobe_d = 1'b1;
              held_d   = 1'b1;
              state_d  = HELD;
            end else begin
              fcnt_d = fcnt_q + 4'd1;
            end
          end else if (is_single) begin
            cand_d = hit_code;
            fcnt_d = 4'd1;
          end else begin
            fcnt_d  = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (is_empty) begin
            fcnt_d = 4'd1;
            if (FRAMES == 4'd1) begin
              key_d   = 4'hF;
              held_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = RELEASE_CHK;
            end
          end
        end
        RELEASE_CHK: begin
          if (is_empty) begin
            if (fcnt_q + 4'd1 >= FRAMES) begin
              fcnt_d  = FRAMES;
              key_d   = 4'hF;
              held_d  = 1'b0;
              state_d = IDLE;
            end else begin
              fcnt_d = fcnt_q + 4'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_idx_q  <= '0;
      slot0_q    <= '1;
      slot1_q    <= '1;
      state_q    <= IDLE;
      fcnt_q     <= '0;
      cand_q     <= '0;
      key_q      <= 4'hF;
      strobe_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      cand_q     <= cand_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
      held_q     <= held_d;
    end
  end

  assign col        = ~(3'b001 << col_idx_q);
  assign keyPadBuf  = key_q;
  assign key_strobe = strobe_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int unsigned SC    = 4;
  localparam int unsigned DEB   = 3;
  localparam int unsigned FRAME = 3 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] kpb;
  logic       stb;
  logic       held;

  // Pressed-key set, bit index = row*3 + col.
  logic [11:0] pressed = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        m_held = 1'b0;
  logic [3:0]  m_key  = 4'hF;
  logic [3:0]  m_runk = 4'hF;
  int unsigned m_run  = 0;

  typedef struct {
    logic [11:0] mask;
    logic [3:0]  key;
    logic        stb;
    logic        held;
  } vec_t;
  vec_t vecs[$];

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .keyPadBuf (kpb),
    .key_strobe(stb),
    .key_held  (held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [3:0] key_code(input int unsigned idx);
    logic [3:0] tbl [12];
    tbl = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
    return tbl[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Applies debounce rules to one frame's worth of pressed keys.
  task automatic model_frame(input logic [11:0] mask, output logic exp_stb);
    int unsigned n;
    logic [3:0]  k;
    n = $countones(mask);
    k = 4'hF;
    for (int unsigned i = 0; i < 12; i++)
      if (mask[i]) k = key_code(i);
    exp_stb = 1'b0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && m_runk == k) m_run++;
        else m_run = 1;
        m_runk = k;
        if (m_run >= DEB) begin
          m_held  = 1'b1;
          m_key   = k;
          exp_stb = 1'b1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_run++;
        if (m_run >= DEB) begin
          m_held = 1'b0;
          m_key  = 4'hF;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Called at frame cycle 0; returns at cycle 0 of the next frame.
  task automatic run_frame(input logic [11:0] mask);
    logic [3:0]  pk;
    logic        ph;
    logic        es;
    logic [2:0]  one;
    logic [2:0]  exp_col;
    int unsigned c;
    pk = m_key;
    ph = m_held;
    one = 3'b001;
    pressed = mask;
    model_frame(mask, es);
    for (int unsigned i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      c = (i + 1) % FRAME;
      exp_col = ~(one << (c / SC));
      check("col", {29'd0, col}, {29'd0, exp_col});
      if (i == FRAME - 1)
        check("outputs{key,held,strobe}", {26'd0, kpb, held, stb}, {26'd0, m_key, m_held, es});
      else
        check("outputs{key,held,strobe}", {26'd0, kpb, held, stb}, {26'd0, pk, ph, 1'b0});
    end
  endtask

  task automatic add(input logic [11:0] mask, input int unsigned n,
                     input logic [3:0] key, input logic s, input logic h);
    vec_t v;
    v.mask = mask;
    v.key  = key;
    v.stb  = s;
    v.held = h;
    for (int unsigned i = 0; i < n; i++) vecs.push_back(v);
  endtask

  localparam logic [11:0] K1 = 12'h001, K3 = 12'h004, K5 = 12'h010, K9 = 12'h100;
  localparam logic [11:0] KSTAR = 12'h200, K0 = 12'h400, KHASH = 12'h800, NONE = 12'h000;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] m;
    int unsigned sel;
    int unsigned a;
    int unsigned b;
    int unsigned reps;

    // Expected outputs after each frame's evaluation edge.
    add(K5, 2, 4'hF, 1'b0, 1'b0);
    add(K5, 1, 4'h5, 1'b1, 1'b1);
    add(K5, 1, 4'h5, 1'b0, 1'b1);
    add(NONE, 2, 4'h5, 1'b0, 1'b1);
    add(NONE, 1, 4'hF, 1'b0, 1'b0);
    add(K9, 2, 4'hF, 1'b0, 1'b0);
    add(NONE, 1, 4'hF, 1'b0, 1'b0);
    add(K9, 2, 4'hF, 1'b0, 1'b0);
    add(NONE, 1, 4'hF, 1'b0, 1'b0);
    add(K1 | K3, 5, 4'hF, 1'b0, 1'b0);
    add(K1, 2, 4'hF, 1'b0, 1'b0);
    add(K1, 1, 4'h1, 1'b1, 1'b1);
    add(NONE, 2, 4'h1, 1'b0, 1'b1);
    add(NONE, 1, 4'hF, 1'b0, 1'b0);
    add(KHASH, 2, 4'hF, 1'b0, 1'b0);
    add(KHASH, 1, 4'hB, 1'b1, 1'b1);
    add(K0, 2, 4'hB, 1'b0, 1'b1);
    add(NONE, 2, 4'hB, 1'b0, 1'b1);
    add(K0, 1, 4'hB, 1'b0, 1'b1);
    add(NONE, 2, 4'hB, 1'b0, 1'b1);
    add(NONE, 1, 4'hF, 1'b0, 1'b0);
    add(KSTAR, 2, 4'hF, 1'b0, 1'b0);
    add(KSTAR, 1, 4'hA, 1'b1, 1'b1);

    // Reset
    rst = 1'b1;
    pressed = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset col", {29'd0, col}, 32'h6);
    check("reset key", {28'd0, kpb}, 32'hF);
    check("reset strobe", {31'd0, stb}, 32'h0);
    check("reset held", {31'd0, held}, 32'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].mask);
      check($sformatf("vec%0d", i), {26'd0, kpb, held, stb},
            {26'd0, vecs[i].key, vecs[i].held, vecs[i].stb});
    end

    // Reset while '*' is held: discarded without strobe, then re-accepted.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset outputs", {26'd0, kpb, held, stb}, {26'd0, 4'hF, 1'b0, 1'b0});
    check("midreset col", {29'd0, col}, 32'h6);
    rst = 1'b0;
    m_held = 1'b0;
    m_key  = 4'hF;
    m_run  = 0;
    run_frame(KSTAR);
    run_frame(KSTAR);
    check("star pending", {26'd0, kpb, held, stb}, {26'd0, 4'hF, 1'b0, 1'b0});
    run_frame(KSTAR);
    check("star reaccept", {26'd0, kpb, held, stb}, {26'd0, 4'hA, 1'b1, 1'b1});

    // Random frames, each pattern held for a few frames
    for (int f = 0; f < 150; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        m = '0;
      end else if (sel < 8) begin
        m = '0;
        m[$urandom_range(0, 11)] = 1'b1;
      end else begin
        a = $urandom_range(0, 11);
        b = (a + $urandom_range(1, 11)) % 12;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      reps = $urandom_range(1, 5);
      for (int r = 0; r < int'(reps); r++) run_frame(m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
